// File: rtl/lc3_controller_mc_pkg.sv
// Shared types and constants for the multicycle LC-3 controller: FSM states,
// datapath select encodings, ALU operations and opcode values.
package lc3_controller_mc_pkg;

    typedef enum logic [4:0] {
        FETCH0, FETCH1, FETCH2, DECODE,
        ALU, BR, JMP, JSR0, JSR1,
        LDADDR, LDRD, LDIND, LDRD2, LDWB,
        STADDR, STRD, STIND, STMDR, STWR,
        LEA, TRAP0, TRAP1, TRAP2, TRAP3,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_EAB = 2'b01,
        PC_BUS = 2'b10
    } selPC_t;

    typedef enum logic [1:0] {
        EAB2_ZERO  = 2'b00,
        EAB2_OFF6  = 2'b01,
        EAB2_OFF9  = 2'b10,
        EAB2_OFF11 = 2'b11
    } selEAB2_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } aluControl_t;

    localparam logic [3:0] OPCODE_BR   = 4'b0000;
    localparam logic [3:0] OPCODE_ADD  = 4'b0001;
    localparam logic [3:0] OPCODE_LD   = 4'b0010;
    localparam logic [3:0] OPCODE_ST   = 4'b0011;
    localparam logic [3:0] OPCODE_JSR  = 4'b0100;
    localparam logic [3:0] OPCODE_AND  = 4'b0101;
    localparam logic [3:0] OPCODE_LDR  = 4'b0110;
    localparam logic [3:0] OPCODE_STR  = 4'b0111;
    localparam logic [3:0] OPCODE_RTI  = 4'b1000;
    localparam logic [3:0] OPCODE_NOT  = 4'b1001;
    localparam logic [3:0] OPCODE_LDI  = 4'b1010;
    localparam logic [3:0] OPCODE_STI  = 4'b1011;
    localparam logic [3:0] OPCODE_JMP  = 4'b1100;
    localparam logic [3:0] OPCODE_RES  = 4'b1101;
    localparam logic [3:0] OPCODE_LEA  = 4'b1110;
    localparam logic [3:0] OPCODE_TRAP = 4'b1111;

    // Branch condition: any requested condition code that is currently set.
    function automatic logic brTaken(input logic [2:0] nzp, input logic n,
                                     input logic z, input logic p);
        return (n & nzp[2]) | (z & nzp[1]) | (p & nzp[0]);
    endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory completion source: either the memReady handshake or a fixed-latency
// counter that runs only while the controller sits in a memory state.
module lc3_mem_wait #(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned MEM_LATENCY   = 32'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic memReady,
    output logic memDone
);

    logic [3:0] waitCnt_r;
    logic       latDone_s;

    assign latDone_s = (waitCnt_r == 4'(MEM_LATENCY - 32'd1));
    assign memDone   = USE_MEM_READY ? memReady : latDone_s;

    // Wait counter: clears whenever an access finishes or no access is in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_r <= 4'd0;
        end else if (!active || memDone) begin
            waitCnt_r <= 4'd0;
        end else begin
            waitCnt_r <= waitCnt_r + 4'd1;
        end
    end

endmodule

// File: rtl/lc3_controller_mc.sv
// Multicycle LC-3 control FSM (all instructions but RTI). Datapath controls are
// decoded from the registered state; illegal and halted are registered flags.
module lc3_controller_mc
    import lc3_controller_mc_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned MEM_LATENCY   = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        flagN,
    input  logic        flagZ,
    input  logic        flagP,
    input  logic        memReady,
    output logic        enaMARM,
    output logic        enaPC,
    output logic        enaMDR,
    output logic        enaALU,
    output logic        selMAR,
    output logic [1:0]  selPC,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        ldPC,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        regWE,
    output logic        flagWE,
    output logic        memWE,
    output logic        memRE,
    output logic        selMDR,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output aluControl_t aluControl,
    output logic        halted,
    output logic        illegal
);

    state_t     state_r;
    logic [3:0] opcode_s;
    logic       memActive_s;
    logic       memDone_s;
    logic       unusedIr_s;

    assign opcode_s    = ir[15:12];
    assign unusedIr_s  = ^ir[5:3];
    assign memActive_s = (state_r == FETCH1) || (state_r == LDRD) || (state_r == LDRD2) ||
                         (state_r == STRD) || (state_r == TRAP2) || (state_r == STWR);

    lc3_mem_wait #(
        .USE_MEM_READY (USE_MEM_READY),
        .MEM_LATENCY   (MEM_LATENCY)
    ) memWait (
        .clk      (clk),
        .reset    (reset),
        .active   (memActive_s),
        .memReady (memReady),
        .memDone  (memDone_s)
    );

    // State sequencing plus the sticky illegal/halted flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH0;
            illegal <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state_r)
                FETCH0: state_r <= FETCH1;
                FETCH1: if (memDone_s) state_r <= FETCH2;
                FETCH2: state_r <= DECODE;
                DECODE: begin
                    case (opcode_s)
                        OPCODE_ADD, OPCODE_AND, OPCODE_NOT:  state_r <= ALU;
                        OPCODE_BR:                           state_r <= BR;
                        OPCODE_JMP:                          state_r <= JMP;
                        OPCODE_JSR:                          state_r <= JSR0;
                        OPCODE_LD, OPCODE_LDR, OPCODE_LDI:   state_r <= LDADDR;
                        OPCODE_ST, OPCODE_STR, OPCODE_STI:   state_r <= STADDR;
                        OPCODE_LEA:                          state_r <= LEA;
                        OPCODE_TRAP:                         state_r <= TRAP0;
                        default: begin
                            state_r <= HALT;
                            illegal <= 1'b1;
                            halted  <= 1'b1;
                        end
                    endcase
                end
                JSR0:   state_r <= JSR1;
                LDADDR: state_r <= LDRD;
                LDRD:   if (memDone_s) state_r <= (opcode_s == OPCODE_LDI) ? LDIND : LDWB;
                LDIND:  state_r <= LDRD2;
                LDRD2:  if (memDone_s) state_r <= LDWB;
                STADDR: state_r <= (opcode_s == OPCODE_STI) ? STRD : STMDR;
                STRD:   if (memDone_s) state_r <= STIND;
                STIND:  state_r <= STMDR;
                STMDR:  state_r <= STWR;
                STWR:   if (memDone_s) state_r <= FETCH0;
                TRAP0:  state_r <= TRAP1;
                TRAP1:  state_r <= TRAP2;
                TRAP2:  if (memDone_s) state_r <= TRAP3;
                HALT: begin
                    state_r <= HALT;
                    halted  <= 1'b1;
                end
                default: state_r <= FETCH0;
            endcase
        end
    end

    // Datapath control decode from the current state
    always_comb begin
        enaMARM    = 1'b0;
        enaPC      = 1'b0;
        enaMDR     = 1'b0;
        enaALU     = 1'b0;
        selMAR     = 1'b0;
        selPC      = PC_INC;
        selEAB1    = 1'b0;
        selEAB2    = EAB2_ZERO;
        ldPC       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        ldIR       = 1'b0;
        regWE      = 1'b0;
        flagWE     = 1'b0;
        memWE      = 1'b0;
        memRE      = 1'b0;
        selMDR     = 1'b0;
        DR         = ir[11:9];
        SR1        = 3'd0;
        SR2        = ir[2:0];
        aluControl = ALU_PASS;
        case (state_r)
            FETCH0: begin
                enaPC = 1'b1;
                ldMAR = 1'b1;
            end
            FETCH1: begin
                memRE  = 1'b1;
                selMDR = 1'b1;
                ldMDR  = memDone_s;
                ldPC   = memDone_s;
            end
            FETCH2: begin
                enaMDR = 1'b1;
                ldIR   = 1'b1;
            end
            ALU: begin
                regWE  = 1'b1;
                enaALU = 1'b1;
                flagWE = 1'b1;
                SR1    = ir[8:6];
                case (opcode_s)
                    OPCODE_ADD: aluControl = ALU_ADD;
                    OPCODE_AND: aluControl = ALU_AND;
                    default:    aluControl = ALU_NOT;
                endcase
            end
            BR: begin
                if (brTaken(ir[11:9], flagN, flagZ, flagP)) begin
                    ldPC    = 1'b1;
                    selPC   = PC_EAB;
                    selEAB2 = EAB2_OFF9;
                end else begin
                    ldPC    = 1'b0;
                end
            end
            JMP: begin
                ldPC    = 1'b1;
                selPC   = PC_EAB;
                selEAB1 = 1'b1;
                SR1     = ir[8:6];
            end
            JSR0, TRAP0: begin
                DR    = 3'd7;
                regWE = 1'b1;
                enaPC = 1'b1;
            end
            JSR1: begin
                ldPC  = 1'b1;
                selPC = PC_EAB;
                if (ir[11]) begin
                    selEAB2 = EAB2_OFF11;
                end else begin
                    selEAB1 = 1'b1;
                    SR1     = ir[8:6];
                end
            end
            LDADDR, STADDR: begin
                ldMAR   = 1'b1;
                enaMARM = 1'b1;
                if ((opcode_s == OPCODE_LDR) || (opcode_s == OPCODE_STR)) begin
                    selEAB1 = 1'b1;
                    selEAB2 = EAB2_OFF6;
                    SR1     = ir[8:6];
                end else begin
                    selEAB2 = EAB2_OFF9;
                end
            end
            LDRD, LDRD2, STRD, TRAP2: begin
                memRE  = 1'b1;
                selMDR = 1'b1;
                ldMDR  = memDone_s;
            end
            LDIND, STIND: begin
                ldMAR  = 1'b1;
                enaMDR = 1'b1;
            end
            LDWB: begin
                regWE  = 1'b1;
                enaMDR = 1'b1;
                flagWE = 1'b1;
            end
            STMDR: begin
                ldMDR  = 1'b1;
                enaALU = 1'b1;
                SR1    = ir[11:9];
            end
            STWR: memWE = 1'b1;
            LEA: begin
                regWE   = 1'b1;
                enaMARM = 1'b1;
                selEAB2 = EAB2_OFF9;
            end
            TRAP1: begin
                ldMAR   = 1'b1;
                enaMARM = 1'b1;
                selMAR  = 1'b1;
            end
            TRAP3: begin
                ldPC   = 1'b1;
                selPC  = PC_BUS;
                enaMDR = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_controller_mc.sv
// Directed bench for lc3_controller_mc: per-cycle expected control words are
// queued as stimulus is driven and compared by a monitor away from the clock edge.
module tb_lc3_controller_mc;
    import lc3_controller_mc_pkg::*;

    typedef struct packed {
        logic enaMARM; logic enaPC; logic enaMDR; logic enaALU; logic selMAR;
        logic [1:0] selPC; logic selEAB1; logic [1:0] selEAB2;
        logic ldPC; logic ldMAR; logic ldMDR; logic ldIR; logic regWE;
        logic flagWE; logic memWE; logic memRE; logic selMDR;
        logic [2:0] DR; logic [2:0] SR1; logic [2:0] SR2;
        aluControl_t aluControl; logic halted; logic illegal;
    } ctl_t;

    logic clk = 1'b0;
    logic reset, flagN, flagZ, flagP, memReady;
    logic [15:0] ir;
    logic [1:0] enaMARM, enaPC, enaMDR, enaALU, selMAR, selEAB1, ldPC, ldMAR, ldMDR, ldIR;
    logic [1:0] regWE, flagWE, memWE, memRE, selMDR, halted, illegal;
    logic [1:0][1:0] selPC, selEAB2;
    logic [1:0][2:0] DR, SR1, SR2;
    aluControl_t aluC [2];

    int checks = 0;
    int errors = 0;
    string tagQ [$];
    ctl_t  expQ [$];
    int    whichQ [$];

    always #5 clk = ~clk;

    lc3_controller_mc #(.USE_MEM_READY(1'b1), .MEM_LATENCY(32'd1)) dutRdy (
        .clk(clk), .reset(reset), .ir(ir), .flagN(flagN), .flagZ(flagZ), .flagP(flagP),
        .memReady(memReady), .enaMARM(enaMARM[0]), .enaPC(enaPC[0]), .enaMDR(enaMDR[0]),
        .enaALU(enaALU[0]), .selMAR(selMAR[0]), .selPC(selPC[0]), .selEAB1(selEAB1[0]),
        .selEAB2(selEAB2[0]), .ldPC(ldPC[0]), .ldMAR(ldMAR[0]), .ldMDR(ldMDR[0]),
        .ldIR(ldIR[0]), .regWE(regWE[0]), .flagWE(flagWE[0]), .memWE(memWE[0]),
        .memRE(memRE[0]), .selMDR(selMDR[0]), .DR(DR[0]), .SR1(SR1[0]), .SR2(SR2[0]),
        .aluControl(aluC[0]), .halted(halted[0]), .illegal(illegal[0]));

    lc3_controller_mc #(.USE_MEM_READY(1'b0), .MEM_LATENCY(32'd3)) dutLat (
        .clk(clk), .reset(reset), .ir(ir), .flagN(flagN), .flagZ(flagZ), .flagP(flagP),
        .memReady(memReady), .enaMARM(enaMARM[1]), .enaPC(enaPC[1]), .enaMDR(enaMDR[1]),
        .enaALU(enaALU[1]), .selMAR(selMAR[1]), .selPC(selPC[1]), .selEAB1(selEAB1[1]),
        .selEAB2(selEAB2[1]), .ldPC(ldPC[1]), .ldMAR(ldMAR[1]), .ldMDR(ldMDR[1]),
        .ldIR(ldIR[1]), .regWE(regWE[1]), .flagWE(flagWE[1]), .memWE(memWE[1]),
        .memRE(memRE[1]), .selMDR(selMDR[1]), .DR(DR[1]), .SR1(SR1[1]), .SR2(SR2[1]),
        .aluControl(aluC[1]), .halted(halted[1]), .illegal(illegal[1]));

    function automatic ctl_t pack(input int w);
        ctl_t a;
        a.enaMARM = enaMARM[w]; a.enaPC = enaPC[w]; a.enaMDR = enaMDR[w];
        a.enaALU = enaALU[w]; a.selMAR = selMAR[w]; a.selPC = selPC[w];
        a.selEAB1 = selEAB1[w]; a.selEAB2 = selEAB2[w]; a.ldPC = ldPC[w];
        a.ldMAR = ldMAR[w]; a.ldMDR = ldMDR[w]; a.ldIR = ldIR[w]; a.regWE = regWE[w];
        a.flagWE = flagWE[w]; a.memWE = memWE[w]; a.memRE = memRE[w];
        a.selMDR = selMDR[w]; a.DR = DR[w]; a.SR1 = SR1[w]; a.SR2 = SR2[w];
        a.aluControl = aluC[w]; a.halted = halted[w]; a.illegal = illegal[w];
        return a;
    endfunction

    // Default control word for the current ir
    function automatic ctl_t dflt(input logic ill, input logic hlt);
        ctl_t e;
        e = '0;
        e.DR = ir[11:9];
        e.SR2 = ir[2:0];
        e.aluControl = ALU_PASS;
        e.illegal = ill;
        e.halted = hlt;
        return e;
    endfunction

    // Scoreboard: compare every control word queued for this cycle
    always @(negedge clk) begin
        #2;
        while (expQ.size() > 0) begin
            automatic string t = tagQ.pop_front();
            automatic ctl_t  x = expQ.pop_front();
            automatic int    w = whichQ.pop_front();
            automatic ctl_t  a = pack(w);
            checks++;
            assert (a === x) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, a, x);
            end
        end
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end else begin
            errors = errors;
        end
    endtask

    task automatic push(input string tag, input ctl_t e, input int which);
        tagQ.push_back(tag);
        expQ.push_back(e);
        whichQ.push_back(which);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step(input string tag, input ctl_t e);
        push(tag, e, 0);
        tick();
    endtask

    // One memory read state: waits cycles with memDone low, then the done cycle
    task automatic rdState(input string tag, input int which, input int waits);
        ctl_t e;
        repeat (waits) begin
            memReady = (which == 1) ? 1'b1 : 1'b0;
            e = dflt(1'b0, 1'b0); e.memRE = 1'b1; e.selMDR = 1'b1;
            push({tag, "_wait"}, e, which);
            tick();
        end
        memReady = (which == 1) ? 1'b0 : 1'b1;
        e = dflt(1'b0, 1'b0); e.memRE = 1'b1; e.selMDR = 1'b1; e.ldMDR = 1'b1;
        push({tag, "_done"}, e, which);
        tick();
        memReady = 1'b0;
    endtask

    // FETCH0 .. DECODE for one instruction; the current cycle must be FETCH0
    task automatic fetch(input int which, input logic [15:0] irv, input int waits);
        ctl_t e;
        ir = irv;
        e = dflt(1'b0, 1'b0); e.enaPC = 1'b1; e.ldMAR = 1'b1;
        push("fetch0", e, which);
        tick();
        repeat (waits) begin
            memReady = (which == 1) ? 1'b1 : 1'b0;
            e = dflt(1'b0, 1'b0); e.memRE = 1'b1; e.selMDR = 1'b1;
            push("fetch1_wait", e, which);
            tick();
        end
        memReady = (which == 1) ? 1'b0 : 1'b1;
        e = dflt(1'b0, 1'b0); e.memRE = 1'b1; e.selMDR = 1'b1; e.ldMDR = 1'b1; e.ldPC = 1'b1;
        push("fetch1_done", e, which);
        tick();
        memReady = 1'b0;
        e = dflt(1'b0, 1'b0); e.enaMDR = 1'b1; e.ldIR = 1'b1;
        push("fetch2", e, which);
        tick();
        push("decode", dflt(1'b0, 1'b0), which);
        tick();
    endtask

    initial begin
        ctl_t e;
        reset = 1'b1; ir = 16'h0000; flagN = 1'b0; flagZ = 1'b0; flagP = 1'b0; memReady = 1'b0;
        tick();
        tick();
        #1;
        chk("reset_illegal_rdy", illegal[0], 1'b0);
        chk("reset_halted_rdy", halted[0], 1'b0);
        chk("reset_memRE_rdy", memRE[0], 1'b0);
        chk("reset_illegal_lat", illegal[1], 1'b0);
        chk("reset_halted_lat", halted[1], 1'b0);
        chk("reset_memRE_lat", memRE[1], 1'b0);
        reset = 1'b0;
        ir = 16'h2005;
        e = dflt(1'b0, 1'b0); e.enaPC = 1'b1; e.ldMAR = 1'b1;
        push("reset_rdy", e, 0);

        // LD x2005 on the fixed-latency controller (3 cycles per access)
        fetch(1, 16'h2005, 2);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selEAB2 = 2'b10;
        push("lat_ldaddr", e, 1); tick();
        rdState("lat_ldrd", 1, 2);
        #1;
        chk("lat_wait_expired_memRE", memRE[1], 1'b0);
        chk("lat_wait_expired_regWE", regWE[1], 1'b1);
        e = dflt(1'b0, 1'b0); e.regWE = 1'b1; e.enaMDR = 1'b1; e.flagWE = 1'b1;
        push("lat_ldwb", e, 1); tick();
        e = dflt(1'b0, 1'b0); e.enaPC = 1'b1; e.ldMAR = 1'b1;
        push("lat_next_fetch0", e, 1);

        reset = 1'b1; tick(); tick(); reset = 1'b0;

        // BR n,p with only Z set: not taken; FETCH1 stalls 3 cycles
        fetch(0, 16'h0A05, 3);
        flagZ = 1'b1;
        step("br_z_not_taken", dflt(1'b0, 1'b0));
        fetch(0, 16'h0A05, 0);
        flagZ = 1'b0; flagP = 1'b1;
        e = dflt(1'b0, 1'b0); e.ldPC = 1'b1; e.selPC = 2'b01; e.selEAB2 = 2'b10;
        step("br_p_taken", e);
        fetch(0, 16'h0005, 1);
        flagN = 1'b1; flagZ = 1'b1; flagP = 1'b1;
        step("br_nzp000", dflt(1'b0, 1'b0));
        flagN = 1'b0; flagZ = 1'b0; flagP = 1'b0;

        // ALU operations
        fetch(0, 16'h1283, 0);
        e = dflt(1'b0, 1'b0); e.regWE = 1'b1; e.enaALU = 1'b1; e.flagWE = 1'b1;
        e.SR1 = 3'd2; e.aluControl = ALU_ADD;
        step("add", e);
        fetch(0, 16'h927F, 0);
        e = dflt(1'b0, 1'b0); e.regWE = 1'b1; e.enaALU = 1'b1; e.flagWE = 1'b1;
        e.SR1 = 3'd1; e.aluControl = ALU_NOT;
        step("not", e);

        // RET, JSR, JSRR
        fetch(0, 16'hC1C0, 0);
        e = dflt(1'b0, 1'b0); e.ldPC = 1'b1; e.selPC = 2'b01; e.selEAB1 = 1'b1; e.SR1 = 3'd7;
        step("jmp", e);
        fetch(0, 16'h4805, 0);
        e = dflt(1'b0, 1'b0); e.DR = 3'd7; e.regWE = 1'b1; e.enaPC = 1'b1;
        step("jsr0", e);
        e = dflt(1'b0, 1'b0); e.ldPC = 1'b1; e.selPC = 2'b01; e.selEAB2 = 2'b11;
        step("jsr1", e);
        fetch(0, 16'h4080, 0);
        e = dflt(1'b0, 1'b0); e.DR = 3'd7; e.regWE = 1'b1; e.enaPC = 1'b1;
        step("jsrr0", e);
        e = dflt(1'b0, 1'b0); e.ldPC = 1'b1; e.selPC = 2'b01; e.selEAB1 = 1'b1; e.SR1 = 3'd2;
        step("jsrr1", e);

        // LDR and LDI
        fetch(0, 16'h6A46, 0);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selEAB1 = 1'b1;
        e.selEAB2 = 2'b01; e.SR1 = 3'd1;
        step("ldr_addr", e);
        rdState("ldr_rd", 0, 1);
        e = dflt(1'b0, 1'b0); e.regWE = 1'b1; e.enaMDR = 1'b1; e.flagWE = 1'b1;
        step("ldr_wb", e);
        fetch(0, 16'hA405, 0);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selEAB2 = 2'b10;
        step("ldi_addr", e);
        rdState("ldi_rd", 0, 0);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMDR = 1'b1;
        step("ldi_ind", e);
        rdState("ldi_rd2", 0, 2);
        e = dflt(1'b0, 1'b0); e.regWE = 1'b1; e.enaMDR = 1'b1; e.flagWE = 1'b1;
        step("ldi_wb", e);

        // STI xB1FF, memReady high outside memory states must be ignored
        fetch(0, 16'hB1FF, 0);
        memReady = 1'b1;
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selEAB2 = 2'b10;
        step("sti_addr", e);
        memReady = 1'b0;
        rdState("sti_rd", 0, 1);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMDR = 1'b1;
        step("sti_ind", e);
        e = dflt(1'b0, 1'b0); e.ldMDR = 1'b1; e.enaALU = 1'b1; e.SR1 = 3'd0;
        step("sti_mdr", e);
        e = dflt(1'b0, 1'b0); e.memWE = 1'b1;
        step("sti_wr_wait0", e);
        step("sti_wr_wait1", e);
        memReady = 1'b1;
        step("sti_wr_done", e);
        memReady = 1'b0;

        // STR skips the indirection read
        fetch(0, 16'h7A46, 0);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selEAB1 = 1'b1;
        e.selEAB2 = 2'b01; e.SR1 = 3'd1;
        step("str_addr", e);
        e = dflt(1'b0, 1'b0); e.ldMDR = 1'b1; e.enaALU = 1'b1; e.SR1 = 3'd5;
        step("str_mdr", e);
        memReady = 1'b1;
        e = dflt(1'b0, 1'b0); e.memWE = 1'b1;
        step("str_wr", e);
        memReady = 1'b0;

        // LEA and TRAP
        fetch(0, 16'hEA10, 0);
        e = dflt(1'b0, 1'b0); e.regWE = 1'b1; e.enaMARM = 1'b1; e.selEAB2 = 2'b10;
        step("lea", e);
        fetch(0, 16'hF025, 0);
        e = dflt(1'b0, 1'b0); e.DR = 3'd7; e.regWE = 1'b1; e.enaPC = 1'b1;
        step("trap0", e);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selMAR = 1'b1;
        step("trap1", e);
        rdState("trap2", 0, 1);
        e = dflt(1'b0, 1'b0); e.ldPC = 1'b1; e.selPC = 2'b10; e.enaMDR = 1'b1;
        step("trap3", e);

        // Reset asserted mid-read drops memRE the following cycle
        fetch(0, 16'h2005, 0);
        e = dflt(1'b0, 1'b0); e.ldMAR = 1'b1; e.enaMARM = 1'b1; e.selEAB2 = 2'b10;
        step("ld_addr", e);
        e = dflt(1'b0, 1'b0); e.memRE = 1'b1; e.selMDR = 1'b1;
        step("ld_rd_wait", e);
        reset = 1'b1;
        step("ld_rd_reset_cycle", e);
        reset = 1'b0;
        #1;
        chk("ld_rd_reset_memRE_drop", memRE[0], 1'b0);

        // Reserved opcode halts; reset leaves HALT
        fetch(0, 16'hD000, 0);
        repeat (2) step("res_halt", dflt(1'b1, 1'b1));
        reset = 1'b1;
        step("halt_reset_cycle", dflt(1'b1, 1'b1));
        reset = 1'b0;

        // RTI opcode: HALT holds for 20 cycles regardless of memReady
        fetch(0, 16'h8000, 0);
        for (int i = 0; i < 20; i++) begin
            memReady = i[0];
            step("rti_halt", dflt(1'b1, 1'b1));
        end
        memReady = 1'b0;
        reset = 1'b1;
        step("rti_reset_cycle", dflt(1'b1, 1'b1));
        reset = 1'b0;
        e = dflt(1'b0, 1'b0); e.enaPC = 1'b1; e.ldMAR = 1'b1;
        step("post_reset_fetch0", e);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
